// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// This block shares one combinational ALU between two requesters:
//   - Port 0 is the integer execute path.
//   - Port 1 is the branch/address unit.
//
// Accepting a request starts a three-phase sequence:
//   IDLE  Arbitrate between the requesters. The accepted operands and control
//         code are registered straight into the ALU input registers.
//   EXEC  The ALU settles for one cycle. At the end of the cycle its outputs
//         are captured into the owner's response registers.
//   RESP  The response is held until the owner consumes it. Round-robin
//         priority then passes to the other requester.
//
// Only one operation is in flight at a time.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   reqN_valid/ready/a/b/ctrl      request handshake and operands, N = 0,1
//   rspN_valid/ready               response handshake, N = 0,1
//   rspN_result/zero/taken/err     held response payload, N = 0,1
//   alu_data0/alu_data1/alu_ctrl   registered ALU operands and control code
//   alu_result/alu_zero/alu_branch ALU outputs, sampled in EXEC
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_taken,
  output logic              rsp0_err,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_taken,
  output logic              rsp1_err,

  output logic [WIDTH-1:0]  alu_data0,
  output logic [WIDTH-1:0]  alu_data1,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  input  logic              alu_branch
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Control code classes:
  //   below BRANCH_BASE          -> arithmetic
  //   BRANCH_BASE .. ILLEGAL_BASE-1 -> branch
  //   ILLEGAL_BASE and above     -> illegal
  localparam logic [CTRL_W-1:0] BRANCH_BASE  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] ILLEGAL_BASE = CTRL_W'(14);

  logic [1:0]            state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  owner_q, owner_d;
  logic [WIDTH-1:0]      alu_data0_q, alu_data0_d;
  logic [WIDTH-1:0]      alu_data1_q, alu_data1_d;
  logic [CTRL_W-1:0]     alu_ctrl_q, alu_ctrl_d;

  // Response registers, indexed by requester number.
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [1:0][WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [1:0]            rsp_zero_q, rsp_zero_d;
  logic [1:0]            rsp_taken_q, rsp_taken_d;
  logic [1:0]            rsp_err_q, rsp_err_d;

  logic                  grant;
  logic [1:0]            rsp_ready_v;

  assign rsp_ready_v = {rsp1_ready, rsp0_ready};

  // Only contention consults rr; a lone requester wins outright.
  assign grant      = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == S_IDLE) && req1_valid && grant;

  always_comb begin
    // NOTE: every signal driven here gets a default first. A path that leaves
    // one unassigned would infer a latch.
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    alu_data0_d  = alu_data0_q;
    alu_data1_d  = alu_data1_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_taken_d  = rsp_taken_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          alu_data0_d = grant ? req1_a    : req0_a;
          alu_data1_d = grant ? req1_b    : req0_b;
          alu_ctrl_d  = grant ? req1_ctrl : req0_ctrl;
          owner_d     = grant;
          state_d     = S_EXEC;
        end
      end

      S_EXEC: begin
        rsp_valid_d[owner_q]  = 1'b1;
        rsp_result_d[owner_q] = '0;
        rsp_zero_d[owner_q]   = 1'b0;
        rsp_taken_d[owner_q]  = 1'b0;
        rsp_err_d[owner_q]    = 1'b0;
        if (alu_ctrl_q >= ILLEGAL_BASE) begin
          rsp_err_d[owner_q] = 1'b1;
        end else if (alu_ctrl_q >= BRANCH_BASE) begin
          rsp_zero_d[owner_q]  = alu_zero;
          rsp_taken_d[owner_q] = alu_branch;
        end else begin
          rsp_result_d[owner_q] = alu_result;
          rsp_zero_d[owner_q]   = alu_zero;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        // The payload and the ALU inputs hold until the owner consumes.
        if (rsp_ready_v[owner_q]) begin
          rsp_valid_d[owner_q] = 1'b0;
          rr_d                 = ~owner_q;
          state_d              = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only. All flops then
    // update together from values sampled before the edge.
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= 1'b0;
      owner_q      <= 1'b0;
      alu_data0_q  <= '0;
      alu_data1_q  <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= '0;
      rsp_taken_q  <= '0;
      rsp_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      alu_data0_q  <= alu_data0_d;
      alu_data1_q  <= alu_data1_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_taken_q  <= rsp_taken_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_data0   = alu_data0_q;
  assign alu_data1   = alu_data1_q;
  assign alu_ctrl    = alu_ctrl_q;

  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp0_result = rsp_result_q[0];
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp0_taken  = rsp_taken_q[0];
  assign rsp0_err    = rsp_err_q[0];

  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp1_result = rsp_result_q[1];
  assign rsp1_zero   = rsp_zero_q[1];
  assign rsp1_taken  = rsp_taken_q[1];
  assign rsp1_err    = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter.
//
// The bench supplies a behavioural ALU on the alu_* side. For branch and
// illegal codes this ALU drives a deliberately non-zero result, so the
// arbiter's result masking is observable.
//
// Expected responses come from a transaction-level reference:
//   - ref_rsp() computes the response from the operands by the code-class rules.
//   - A small scoreboard tracks the grant, the latency and the round-robin
//     owner across randomized traffic.
//
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  logic              clk;
  logic              rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic              rsp0_valid, rsp0_ready, rsp0_zero, rsp0_taken, rsp0_err;
  logic              rsp1_valid, rsp1_ready, rsp1_zero, rsp1_taken, rsp1_err;
  logic [WIDTH-1:0]  rsp0_result, rsp1_result;
  logic [WIDTH-1:0]  alu_data0, alu_data1, alu_result;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              alu_zero, alu_branch;

  int vectors     = 0;
  int miscompares = 0;

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ctrl   (req0_ctrl),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ctrl   (req1_ctrl),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp0_taken  (rsp0_taken),
    .rsp0_err    (rsp0_err),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .rsp1_taken  (rsp1_taken),
    .rsp1_err    (rsp1_err),
    .alu_data0   (alu_data0),
    .alu_data1   (alu_data1),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_branch  (alu_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Behavioural ALU. Branch and illegal codes produce junk results on purpose.
  always_comb begin
    alu_result = alu_data0 ^ alu_data1 ^ 32'hDEAD_BEEF;
    alu_zero   = (alu_data0 == alu_data1);
    alu_branch = 1'b0;
    case (alu_ctrl)
      4'd0:  alu_result = alu_data0 + alu_data1;
      4'd1:  alu_result = alu_data0 - alu_data1;
      4'd2:  alu_result = alu_data0 << alu_data1[4:0];
      4'd3:  alu_result = alu_data0 ^ alu_data1;
      4'd4:  alu_result = alu_data0 >> alu_data1[4:0];
      4'd5:  alu_result = 32'($signed(alu_data0) >>> alu_data1[4:0]);
      4'd6:  alu_result = alu_data0 | alu_data1;
      4'd7:  alu_result = alu_data0 & alu_data1;
      4'd8:  begin alu_result = alu_data0 - alu_data1; alu_branch = $signed(alu_data0) <  $signed(alu_data1); end
      4'd9:  begin alu_result = alu_data0 - alu_data1; alu_branch = $signed(alu_data0) >= $signed(alu_data1); end
      4'd10: begin alu_result = alu_data0 - alu_data1; alu_branch = alu_data0 <  alu_data1; end
      4'd11: begin alu_result = alu_data0 - alu_data1; alu_branch = alu_data0 >= alu_data1; end
      4'd12: begin alu_result = alu_data0 - alu_data1; alu_branch = alu_data0 == alu_data1; end
      4'd13: begin alu_result = alu_data0 - alu_data1; alu_branch = alu_data0 != alu_data1; end
      default: ;
    endcase
  end

  // Response packed as {valid, result, zero, taken, err}.
  logic [35:0] rsp0_bus, rsp1_bus;
  assign rsp0_bus = {rsp0_valid, rsp0_result, rsp0_zero, rsp0_taken, rsp0_err};
  assign rsp1_bus = {rsp1_valid, rsp1_result, rsp1_zero, rsp1_taken, rsp1_err};

  // Reference response {result, zero, taken, err}, derived from the operands.
  function automatic logic [34:0] ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [31:0] r;
    logic        t;
    r = '0;
    t = 1'b0;
    if (c >= 4'd14) return {32'd0, 1'b0, 1'b0, 1'b1};
    if (c >= 4'd8) begin
      case (c)
        4'd8:    t = $signed(a) <  $signed(b);
        4'd9:    t = $signed(a) >= $signed(b);
        4'd10:   t = a <  b;
        4'd11:   t = a >= b;
        4'd12:   t = a == b;
        default: t = a != b;
      endcase
      return {32'd0, a == b, t, 1'b0};
    end
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << b[4:0];
      4'd3:    r = a ^ b;
      4'd4:    r = a >> b[4:0];
      4'd5:    r = 32'($signed(a) >>> b[4:0]);
      4'd6:    r = a | b;
      default: r = a & b;
    endcase
    return {r, a == b, 1'b0, 1'b0};
  endfunction

  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One operation on a single port, with no contention and no backpressure.
  // Checks the grant, the EXEC-cycle ALU inputs, response timing and payload,
  // and that the response clears after it is consumed.
  task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [34:0] exp, input string name);
    int   waited;
    logic rdy;
    @(negedge clk);
    set_req(p, 1'b1, a, b, c);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    waited = 0;
    #1;
    rdy = (p == 0) ? req0_ready : req1_ready;
    while (!rdy && waited < 10) begin
      @(negedge clk); #1;
      rdy = (p == 0) ? req0_ready : req1_ready;
      waited++;
    end
    vectors++;
    if (!rdy) begin
      miscompares++;
      $display("FAIL %s grant: ready never rose within 10 cycles", name);
      set_req(p, 1'b0, a, b, c);
      return;
    end
    vectors++;
    if (((p == 0) ? req1_ready : req0_ready) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s other_ready: got 1 expected 0", name);
    end
    @(negedge clk);
    set_req(p, 1'b0, a, b, c);
    #1;
    vectors++;
    if ({rsp1_valid, rsp0_valid, alu_data0, alu_data1, alu_ctrl} !== {2'b00, a, b, c}) begin
      miscompares++;
      $display("FAIL %s exec: valids=%b alu=%h/%h/%h expected 00 %h/%h/%h", name,
               {rsp1_valid, rsp0_valid}, alu_data0, alu_data1, alu_ctrl, a, b, c);
    end
    @(negedge clk); #1;
    vectors++;
    if (((p == 0) ? rsp0_bus : rsp1_bus) !== {1'b1, exp}) begin
      miscompares++;
      $display("FAIL %s rsp: got %h expected %h", name, (p == 0) ? rsp0_bus : rsp1_bus, {1'b1, exp});
    end
    vectors++;
    if (((p == 0) ? rsp1_valid : rsp0_valid) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s other_rsp_valid: got 1 expected 0", name);
    end
    if (p == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s consume: valids=%b expected 00", name, {rsp1_valid, rsp0_valid});
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({req1_ready, req0_ready, rsp1_bus, rsp0_bus, alu_data0, alu_data1, alu_ctrl} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b rsp0=%h rsp1=%h alu=%h/%h/%h expected all zero",
               {req1_ready, req0_ready}, rsp0_bus, rsp1_bus, alu_data0, alu_data1, alu_ctrl);
    end
  endtask

  task automatic test_single_add();
    run_op(0, 32'd5, 32'd7, 4'b0000, {32'd12, 1'b0, 1'b0, 1'b0}, "add_5_7");
  endtask

  task automatic test_branches();
    run_op(1, 32'hFFFF_FFFF, 32'd1, 4'b1000, {32'd0, 1'b0, 1'b1, 1'b0}, "blt_signed");
    run_op(1, 32'hFFFF_FFFF, 32'd1, 4'b1010, {32'd0, 1'b0, 1'b0, 1'b0}, "bltu_unsigned");
    run_op(1, 32'h1234, 32'h1234, 4'b1100, {32'd0, 1'b1, 1'b1, 1'b0}, "beq_equal");
  endtask

  task automatic test_round_robin();
    int   exp_port;
    int   waited;
    logic [34:0] exp;
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 32'd10, 32'd3, 4'b0001);
    set_req(1, 1'b1, 32'hF0, 32'h0F, 4'b0011);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    exp_port = 0;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      #1;
      while (!(req0_ready || req1_ready) && waited < 10) begin
        @(negedge clk); #1;
        waited++;
      end
      vectors++;
      if ({req1_ready, req0_ready} !== ((exp_port == 1) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: ready=%b expected port %0d", k, {req1_ready, req0_ready}, exp_port);
      end
      exp = (exp_port == 0) ? {32'd7, 1'b0, 1'b0, 1'b0} : {32'hFF, 1'b0, 1'b0, 1'b0};
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (((exp_port == 0) ? rsp0_bus : rsp1_bus) !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL rr_rsp[%0d]: got %h expected %h", k,
                 (exp_port == 0) ? rsp0_bus : rsp1_bus, {1'b1, exp});
      end
      exp_port = 1 - exp_port;
      @(negedge clk);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 32'd100, 32'd23, 4'b0000);
    set_req(1, 1'b1, 32'hF0F0, 32'hFF00, 4'b0111);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_grant: ready=%b expected 01", {req1_ready, req0_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp0_bus, alu_data0, alu_data1, alu_ctrl, req1_ready, rsp1_valid} !==
          {1'b1, 32'd123, 3'b000, 32'd100, 32'd23, 4'b0000, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: rsp0=%h alu=%h/%h/%h req1_ready=%b rsp1_valid=%b", i,
                 rsp0_bus, alu_data0, alu_data1, alu_ctrl, req1_ready, rsp1_valid);
      end
      @(negedge clk); #1;
    end
    // Consume the response with both requesters valid: rr now favours port 1.
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_valid = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({rsp0_valid, req1_ready, req0_ready} !== 3'b010) begin
      miscompares++;
      $display("FAIL bp_release: rsp0_valid=%b ready=%b expected 0 10", rsp0_valid,
               {req1_ready, req0_ready});
    end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (rsp1_bus !== {1'b1, 32'hF000, 3'b000}) begin
      miscompares++;
      $display("FAIL bp_port1_rsp: got %h expected %h", rsp1_bus, {1'b1, 32'hF000, 3'b000});
    end
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic test_illegal();
    run_op(0, 32'd3, 32'd3, 4'b1110, {32'd0, 1'b0, 1'b0, 1'b1}, "illegal_1110");
    run_op(0, 32'h8000_0000, 32'd4, 4'b0101, {32'hF800_0000, 1'b0, 1'b0, 1'b0}, "sra_after_illegal");
  endtask

  task automatic test_reset_mid_op();
    run_op(0, 32'd1, 32'd1, 4'b0000, {32'd2, 1'b1, 1'b0, 1'b0}, "pre_reset_add");
    @(negedge clk);
    set_req(1, 1'b1, 32'd2, 32'd2, 4'b0000);
    #1;
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_grant: req1_ready=%b expected 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({rsp1_valid, rsp0_valid, alu_data0, alu_data1, alu_ctrl} !== '0) begin
      miscompares++;
      $display("FAIL midrst_state: valids=%b alu=%h/%h/%h expected zero",
               {rsp1_valid, rsp0_valid}, alu_data0, alu_data1, alu_ctrl);
    end
    rst = 1'b0;
    // rr was 1 before reset; after reset contention must go to port 0.
    @(negedge clk);
    set_req(0, 1'b1, 32'd9, 32'd9, 4'b0000);
    set_req(1, 1'b1, 32'd2, 32'd2, 4'b0000);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_rr: ready=%b expected 01", {req1_ready, req0_ready});
    end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({rsp1_valid, rsp0_bus} !== {1'b0, 1'b1, 32'd18, 3'b100}) begin
      miscompares++;
      $display("FAIL midrst_rsp0: rsp1_valid=%b rsp0=%h expected 0 %h", rsp1_valid, rsp0_bus,
               {1'b1, 32'd18, 3'b100});
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    run_op(1, 32'd2, 32'd2, 4'b0000, {32'd4, 1'b1, 1'b0, 1'b0}, "reissue_port1");
  endtask

  // Random traffic against a transaction-level scoreboard.
  task automatic test_random();
    logic        model_rr;
    logic        outstanding;
    logic        out_port;
    int          age;
    int          completed;
    logic [34:0] exp_rsp;
    logic [67:0] exp_alu;
    logic        g;
    logic [1:0]  exp_rdy;
    do_reset();
    model_rr    = 1'b0;
    outstanding = 1'b0;
    out_port    = 1'b0;
    age         = 0;
    completed   = 0;
    exp_rsp     = '0;
    exp_alu     = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_req(p, ($urandom_range(0, 9) < 6), a, b, 4'($urandom_range(0, 15)));
      end
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (outstanding) begin
        age++;
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
          miscompares++;
          $display("FAIL rand_busy_ready[%0d]: ready=%b expected 00", cyc, {req1_ready, req0_ready});
        end
        if (age == 1) begin
          vectors++;
          if ({rsp1_valid, rsp0_valid, alu_data0, alu_data1, alu_ctrl} !== {2'b00, exp_alu}) begin
            miscompares++;
            $display("FAIL rand_exec[%0d]: valids=%b alu=%h expected 00 %h", cyc,
                     {rsp1_valid, rsp0_valid}, {alu_data0, alu_data1, alu_ctrl}, exp_alu);
          end
        end else begin
          vectors++;
          if ({(out_port ? rsp1_bus : rsp0_bus), (out_port ? rsp0_valid : rsp1_valid)} !==
              {1'b1, exp_rsp, 1'b0}) begin
            miscompares++;
            $display("FAIL rand_rsp[%0d]: port %0d got %h other_valid=%b expected %h", cyc,
                     out_port, out_port ? rsp1_bus : rsp0_bus,
                     out_port ? rsp0_valid : rsp1_valid, {1'b1, exp_rsp});
          end
          if (out_port ? rsp1_ready : rsp0_ready) begin
            outstanding = 1'b0;
            model_rr    = ~out_port;
            completed++;
          end
        end
      end else begin
        vectors++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
          miscompares++;
          $display("FAIL rand_idle_valid[%0d]: valids=%b expected 00", cyc, {rsp1_valid, rsp0_valid});
        end
        if (req0_valid && req1_valid) g = model_rr;
        else                          g = req1_valid;
        exp_rdy = (!req0_valid && !req1_valid) ? 2'b00 : (g ? 2'b10 : 2'b01);
        vectors++;
        if ({req1_ready, req0_ready} !== exp_rdy) begin
          miscompares++;
          $display("FAIL rand_grant[%0d]: ready=%b expected %b", cyc, {req1_ready, req0_ready}, exp_rdy);
        end
        if (exp_rdy != 2'b00) begin
          outstanding = 1'b1;
          out_port    = g;
          age         = 0;
          exp_rsp     = g ? ref_rsp(req1_a, req1_b, req1_ctrl) : ref_rsp(req0_a, req0_b, req0_ctrl);
          exp_alu     = g ? {req1_a, req1_b, req1_ctrl} : {req0_a, req0_b, req0_ctrl};
        end
      end
    end
    vectors++;
    if (completed < 20) begin
      miscompares++;
      $display("FAIL rand_progress: completed %0d ops, expected at least 20", completed);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    test_reset();
    test_single_add();
    test_branches();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
